// File: rtl/iir_out_capture_pkg.sv
// Shared types and constants for the IIR output capture block.
// Optional CRC over captured samples is enabled by defining IIR_CAP_CRC_EN.
package iir_cap_pkg;
  localparam int DW_DEF    = 16;
  localparam int DEPTH_DEF = 2048;
  localparam int AW_DEF    = 11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  // Full-scale codes counted as clipped samples
  localparam logic [15:0] CLIP_POS = 16'h7FFF;
  localparam logic [15:0] CLIP_NEG = 16'h8000;

  // CRC-16/CCITT, MSB-first, no final XOR
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // One 16-bit word per call, MSB first (high byte then low byte);
  // the loop unrolls into a single combinational update.
  function automatic logic [15:0] crc16_word(input logic [15:0] crc,
                                             input logic [15:0] d);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    return c;
  endfunction
endpackage

// File: rtl/iir_out_capture_if.sv
// Filter-facing sample stream plus host read port of the capture block.
interface iir_cap_if #(parameter int DW = 16, parameter int AW = 11);
  logic          stable_in;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  modport master (output stable_in, din, din_valid, rd_en, rd_addr,
                  input  rd_data, rd_valid);
  modport slave  (input  stable_in, din, din_valid, rd_en, rd_addr,
                  output rd_data, rd_valid);
endinterface

// File: rtl/iir_out_capture_ram.sv
// Single-port synchronous sample buffer with registered read.
// Contents are deliberately not reset.
module iir_cap_ram #(
  parameter int DW    = 16,
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  // Write wins; read output only moves on a read so it holds otherwise
  always_ff @(posedge clk) begin
    if (we)      mem[addr] <= wdata;
    else if (re) rdata     <= mem[addr];
  end
endmodule

// File: rtl/iir_out_capture.sv
// Captures one frame of settled filter output, tracks peak |x| and clip
// count, then serves the frame through a 1-cycle read port.
// Optional: IIR_CAP_CRC_EN adds crc_out (CRC-16/CCITT over the frame).
module iir_out_capture
  import iir_cap_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm,
  iir_cap_if.slave      bus,
  output logic          busy,
  output logic          cap_done,
  output logic [AW:0]   cap_count,
  output logic [DW-1:0] peak_abs,
`ifdef IIR_CAP_CRC_EN
  output logic [15:0]   crc_out,
`endif
  output logic [AW:0]   clip_cnt
);
  cap_state_t    state, state_nxt;
  logic          wr, rd_acc, arm_acc;
  logic          zero_q;
  logic [DW-1:0] ram_q, mag;
  logic [AW-1:0] ram_addr;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus write/read/arm qualifiers; arm is only honoured when idle
  always_comb begin
    state_nxt = state;
    wr        = 1'b0;
    rd_acc    = 1'b0;
    arm_acc   = 1'b0;
    case (state)
      IDLE, DONE: begin
        rd_acc = bus.rd_en;
        if (arm) begin
          arm_acc   = 1'b1;
          state_nxt = ARM;
        end
      end
      ARM:
        if (bus.stable_in) state_nxt = CAPTURE;
      CAPTURE:
        if (bus.din_valid) begin
          wr = 1'b1;
          if (cap_count == (AW+1)'(DEPTH-1)) state_nxt = DONE;
        end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state == ARM) || (state == CAPTURE);
  assign cap_done = (state == DONE);
  assign mag      = bus.din[DW-1] ? -bus.din : bus.din;

  // Frame statistics, cleared by an accepted arm
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_count <= '0;
      peak_abs  <= '0;
      clip_cnt  <= '0;
    end else if (arm_acc) begin
      cap_count <= '0;
      peak_abs  <= '0;
      clip_cnt  <= '0;
    end else if (wr) begin
      cap_count <= cap_count + (AW+1)'(1);
      if (mag > peak_abs) peak_abs <= mag;
      if (bus.din == CLIP_POS[DW-1:0] || bus.din == CLIP_NEG[DW-1:0])
        clip_cnt <= clip_cnt + (AW+1)'(1);
    end
  end

  // Capture owns the RAM address; reads only happen in IDLE/DONE
  assign ram_addr = (state == CAPTURE) ? cap_count[AW-1:0] : bus.rd_addr;

  iir_cap_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk  (clk),
    .we   (wr),
    .re   (rd_acc),
    .addr (ram_addr),
    .wdata(bus.din),
    .rdata(ram_q)
  );

  // Read response: out-of-range addresses return zero; zero_q starts set
  // so rd_data reads 0 out of reset regardless of RAM contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd_valid <= 1'b0;
      zero_q       <= 1'b1;
    end else begin
      bus.rd_valid <= rd_acc;
      if (rd_acc) zero_q <= ({1'b0, bus.rd_addr} >= cap_count);
    end
  end

  assign bus.rd_data = zero_q ? '0 : ram_q;

`ifdef IIR_CAP_CRC_EN
  // Running CRC, one sample per accepted write
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          crc_out <= CRC_INIT;
    else if (arm_acc) crc_out <= CRC_INIT;
    else if (wr)      crc_out <= crc16_word(crc_out, 16'(bus.din));
  end
`endif
endmodule

// File: tb/tb_iir_out_capture.sv
// Directed self-checking bench for iir_out_capture (default DEPTH = 2048).
module tb_iir_out_capture;
  localparam int DW = 16, DEPTH = 2048, AW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm;
  logic          busy, cap_done;
  logic [AW:0]   cap_count, clip_cnt;
  logic [DW-1:0] peak_abs;
`ifdef IIR_CAP_CRC_EN
  logic [15:0]   crc_out;
  logic [15:0]   crc_exp;
`endif
  int checks   = 0;
  int failures = 0;

  iir_cap_if #(.DW(DW), .AW(AW)) bus ();

  iir_out_capture #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .arm      (arm),
    .bus      (bus.slave),
    .busy     (busy),
    .cap_done (cap_done),
    .cap_count(cap_count),
    .peak_abs (peak_abs),
`ifdef IIR_CAP_CRC_EN
    .crc_out  (crc_out),
`endif
    .clip_cnt (clip_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [DW-1:0] v);
    bus.din       = v;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

`ifdef IIR_CAP_CRC_EN
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction
`endif

  task automatic test_reset();
    rst = 1'b1; arm = 1'b0;
    bus.stable_in = 1'b0; bus.din = '0; bus.din_valid = 1'b0;
    bus.rd_en = 1'b0; bus.rd_addr = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({busy, cap_done, cap_count, peak_abs, clip_cnt, bus.rd_valid, bus.rd_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b done=%b cnt=%0d peak=%h clip=%0d rv=%b rd=%h, all must be 0",
               busy, cap_done, cap_count, peak_abs, clip_cnt, bus.rd_valid, bus.rd_data);
    end
`ifdef IIR_CAP_CRC_EN
    checks++;
    if (crc_out !== 16'hFFFF) begin
      failures++; $display("FAIL reset_crc: got %h want ffff", crc_out);
    end
`endif
  endtask

  task automatic test_ramp();
    pulse_arm();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL ramp_busy: got %b want 1", busy); end
    repeat (5) tick();
    bus.stable_in = 1'b1;
    tick();
`ifdef IIR_CAP_CRC_EN
    crc_exp = 16'hFFFF;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      feed(16'(i));
`ifdef IIR_CAP_CRC_EN
      crc_exp = crc_byte(crc_byte(crc_exp, 8'(i >> 8)), 8'(i));
`endif
      if (i == DEPTH - 2) begin
        checks++;
        if (cap_done !== 1'b0 || cap_count !== 12'd2047) begin
          failures++;
          $display("FAIL ramp_before_last: done=%b cnt=%0d want 0/2047", cap_done, cap_count);
        end
      end
    end
    checks++;
    if (cap_done !== 1'b1 || busy !== 1'b0 || cap_count !== 12'd2048) begin
      failures++;
      $display("FAIL ramp_done: done=%b busy=%b cnt=%0d want 1/0/2048", cap_done, busy, cap_count);
    end
    checks++;
    if (peak_abs !== 16'h07FF || clip_cnt !== 12'd0) begin
      failures++; $display("FAIL ramp_stats: peak=%h clip=%0d want 07ff/0", peak_abs, clip_cnt);
    end
`ifdef IIR_CAP_CRC_EN
    checks++;
    if (crc_out !== crc_exp) begin
      failures++; $display("FAIL ramp_crc: got %h want %h", crc_out, crc_exp);
    end
`endif
    bus.rd_en = 1'b1; bus.rd_addr = 11'd100;
    tick();
    bus.rd_en = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h0064) begin
      failures++; $display("FAIL ramp_read100: rv=%b data=%h want 1/0064", bus.rd_valid, bus.rd_data);
    end
    tick();
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 16'h0064) begin
      failures++; $display("FAIL read_hold: rv=%b data=%h want 0/0064", bus.rd_valid, bus.rd_data);
    end
  endtask

  task automatic test_arm_gating();
    bus.stable_in = 1'b0;
    pulse_arm();
    checks++;
    if (cap_count !== '0 || peak_abs !== '0 || clip_cnt !== '0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rearm_clear: cnt=%0d peak=%h clip=%0d busy=%b want 0/0/0/1", cap_count, peak_abs, clip_cnt, busy);
    end
    bus.din = 16'h1111;
    for (int i = 0; i < 20; i++) begin
      bus.din_valid = ~i[0];
      bus.rd_en = 1'b1; bus.rd_addr = 11'd3;
      tick();
    end
    bus.rd_en = 1'b0;
    checks++;
    if (cap_count !== '0 || bus.rd_valid !== 1'b0) begin
      failures++; $display("FAIL arm_no_write: cnt=%0d rv=%b want 0/0", cap_count, bus.rd_valid);
    end
    bus.stable_in = 1'b1; bus.din = 16'h5555; bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    checks++;
    if (cap_count !== '0) begin
      failures++; $display("FAIL arm_edge_no_write: cnt=%0d want 0", cap_count);
    end
  endtask

  task automatic test_peak_clip();
    feed(16'h8000); feed(16'h7FFF); feed(16'hFFFF);
    bus.stable_in = 1'b0;
    repeat (3) tick();
    checks++;
    if (cap_count !== 12'd3 || clip_cnt !== 12'd2 || peak_abs !== 16'h8000) begin
      failures++; $display("FAIL clip_partial: cnt=%0d clip=%0d peak=%h want 3/2/8000", cap_count, clip_cnt, peak_abs);
    end
    for (int i = 0; i < DEPTH - 3; i++) feed(16'h0000);
    checks++;
    if (cap_done !== 1'b1 || peak_abs !== 16'h8000 || clip_cnt !== 12'd2) begin
      failures++; $display("FAIL clip_final: done=%b peak=%h clip=%0d want 1/8000/2", cap_done, peak_abs, clip_cnt);
    end
    bus.rd_en = 1'b1; bus.rd_addr = 11'd2;
    tick();
    bus.rd_en = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'hFFFF) begin
      failures++; $display("FAIL clip_read2: rv=%b data=%h want 1/ffff", bus.rd_valid, bus.rd_data);
    end
  endtask

  task automatic test_reset_abort();
    bus.stable_in = 1'b1;
    pulse_arm();
    tick();
    for (int i = 0; i < 700; i++) feed(16'(i + 7));
    checks++;
    if (cap_count !== 12'd700) begin
      failures++; $display("FAIL abort_pre: cnt=%0d want 700", cap_count);
    end
    rst = 1'b1;
    #2;
    checks++;
    if ({busy, cap_done, cap_count, peak_abs, clip_cnt, bus.rd_valid, bus.rd_data} !== '0) begin
      failures++;
      $display("FAIL abort_reset: busy=%b done=%b cnt=%0d peak=%h clip=%0d rv=%b rd=%h want all 0",
               busy, cap_done, cap_count, peak_abs, clip_cnt, bus.rd_valid, bus.rd_data);
    end
    tick();
    rst = 1'b0;
    tick();
    bus.rd_en = 1'b1; bus.rd_addr = 11'd5;
    tick();
    bus.rd_en = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h0000 || busy !== 1'b0) begin
      failures++; $display("FAIL abort_read5: rv=%b data=%h busy=%b want 1/0000/0", bus.rd_valid, bus.rd_data, busy);
    end
  endtask

  task automatic test_arm_ignored();
    bus.stable_in = 1'b1;
    pulse_arm();
    tick();
    for (int i = 0; i < 300; i++) feed(-16'(i));
    arm = 1'b1;
    feed(-16'd300);
    arm = 1'b0;
    checks++;
    if (cap_count !== 12'd301 || busy !== 1'b1) begin
      failures++; $display("FAIL arm_in_capture: cnt=%0d busy=%b want 301/1", cap_count, busy);
    end
    for (int i = 301; i < DEPTH; i++) feed(-16'(i));
    checks++;
    if (cap_done !== 1'b1 || cap_count !== 12'd2048 || peak_abs !== 16'h07FF || clip_cnt !== '0) begin
      failures++;
      $display("FAIL neg_frame: done=%b cnt=%0d peak=%h clip=%0d want 1/2048/07ff/0", cap_done, cap_count, peak_abs, clip_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bus.rd_en = 1'b1; bus.rd_addr = 11'd1;
    tick();
    bus.rd_addr = 11'd2047;
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'hFFFF) begin
      failures++; $display("FAIL b2b_first: rv=%b data=%h want 1/ffff", bus.rd_valid, bus.rd_data);
    end
    tick();
    bus.rd_en = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'hF801) begin
      failures++; $display("FAIL b2b_second: rv=%b data=%h want 1/f801", bus.rd_valid, bus.rd_data);
    end
    pulse_arm();
    checks++;
    if (cap_count !== '0 || peak_abs !== '0 || clip_cnt !== '0 || cap_done !== 1'b0) begin
      failures++;
      $display("FAIL done_rearm: cnt=%0d peak=%h clip=%0d done=%b want 0/0/0/0", cap_count, peak_abs, clip_cnt, cap_done);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_arm_gating();
    test_peak_clip();
    test_reset_abort();
    test_arm_ignored();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
